// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_OPC   = 3'd1,
      ST_ADDR  = 3'd2,
      ST_DATA  = 3'd3,
      ST_CSUM  = 3'd4,
      ST_ISSUE = 3'd5
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] OPC_WRITE = 8'h01;
   localparam logic [7:0] OPC_READ  = 8'h02;

   localparam logic [1:0] ERR_OPC     = 2'b01;
   localparam logic [1:0] ERR_CSUM    = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   // True for the two opcodes the controller understands.
   function automatic logic is_valid_opc(input logic [7:0] b);
      return (b == OPC_WRITE) || (b == OPC_READ);
   endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle counter; expire flags the last allowed idle cycle.
module uart_cmd_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_limit;

   assign w_at_limit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign expire     = enable && w_at_limit;

   // Count idle cycles while enabled, holding at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable && !w_at_limit) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses UART byte frames into single bus read/write commands.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic                  cmd_write,
   output logic [ADDR_WIDTH-1:0] cmd_addr,
   output logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  err_valid,
   output logic [1:0]            err_code,
   output logic [15:0]           frame_cnt,
   output logic [7:0]            err_cnt
);

   localparam int unsigned ADDR_BYTES = ADDR_WIDTH / 8;
   localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
   localparam int unsigned BCNT_W     = 8;

   state_t                r_state;
   logic                  r_rx_ready;
   logic                  r_cmd_valid;
   logic                  r_cmd_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [7:0]            r_csum;
   logic [BCNT_W-1:0]     r_byte_cnt;
   logic                  r_err_valid;
   logic [1:0]            r_err_code;
   logic [15:0]           r_frame_cnt;
   logic [7:0]            r_err_cnt;

   logic                  w_xfer;
   logic                  w_expire;
   logic                  w_tmo_en;
   logic                  w_tmo_clr;
   logic                  w_last_addr;
   logic                  w_last_data;
   logic                  w_err;
   logic [1:0]            w_err_code;

   assign w_xfer      = rx_valid && r_rx_ready;
   assign w_last_addr = (r_byte_cnt == BCNT_W'(ADDR_BYTES - 1));
   assign w_last_data = (r_byte_cnt == BCNT_W'(DATA_BYTES - 1));
   assign w_tmo_en    = (r_state == ST_OPC) || (r_state == ST_ADDR) ||
                        (r_state == ST_DATA) || (r_state == ST_CSUM);
   assign w_tmo_clr   = w_xfer || (r_state == ST_IDLE);

   uart_cmd_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (clk),
      .rst   (rst),
      .clear (w_tmo_clr),
      .enable(w_tmo_en),
      .expire(w_expire)
   );

   // Error detection: bad opcode, checksum mismatch, or idle timeout (a byte this cycle wins).
   always_comb begin
      w_err      = 1'b0;
      w_err_code = ERR_OPC;
      if (!w_xfer && w_expire) begin
         w_err      = 1'b1;
         w_err_code = ERR_TIMEOUT;
      end else if (w_xfer && (r_state == ST_OPC) && !is_valid_opc(rx_data)) begin
         w_err      = 1'b1;
         w_err_code = ERR_OPC;
      end else if (w_xfer && (r_state == ST_CSUM) && (rx_data != r_csum)) begin
         w_err      = 1'b1;
         w_err_code = ERR_CSUM;
      end
   end

   // Frame-parsing FSM with registered command, error and statistics outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_rx_ready  <= 1'b1;
         r_cmd_valid <= 1'b0;
         r_cmd_write <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_csum      <= '0;
         r_byte_cnt  <= '0;
         r_err_valid <= 1'b0;
         r_err_code  <= '0;
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_err_valid <= 1'b0;
         if (w_err) begin
            r_state     <= ST_IDLE;
            r_rx_ready  <= 1'b1;
            r_err_valid <= 1'b1;
            r_err_code  <= w_err_code;
            if (r_err_cnt != 8'hFF) begin
               r_err_cnt <= r_err_cnt + 8'd1;
            end
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_xfer && (rx_data == SYNC_BYTE)) begin
                     r_state <= ST_OPC;
                  end
               end
               ST_OPC: begin
                  if (w_xfer) begin
                     r_cmd_write <= (rx_data == OPC_WRITE);
                     r_csum      <= rx_data;
                     r_wdata     <= '0;
                     r_byte_cnt  <= '0;
                     r_state     <= ST_ADDR;
                  end
               end
               ST_ADDR: begin
                  if (w_xfer) begin
                     r_addr <= (r_addr << 8) | ADDR_WIDTH'(rx_data);
                     r_csum <= r_csum ^ rx_data;
                     if (w_last_addr) begin
                        r_byte_cnt <= '0;
                        r_state    <= r_cmd_write ? ST_DATA : ST_CSUM;
                     end else begin
                        r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
                     end
                  end
               end
               ST_DATA: begin
                  if (w_xfer) begin
                     r_wdata <= (r_wdata << 8) | DATA_WIDTH'(rx_data);
                     r_csum  <= r_csum ^ rx_data;
                     if (w_last_data) begin
                        r_byte_cnt <= '0;
                        r_state    <= ST_CSUM;
                     end else begin
                        r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
                     end
                  end
               end
               ST_CSUM: begin
                  if (w_xfer) begin
                     r_state     <= ST_ISSUE;
                     r_cmd_valid <= 1'b1;
                     r_rx_ready  <= 1'b0;
                  end
               end
               ST_ISSUE: begin
                  if (r_cmd_valid && cmd_ready) begin
                     r_cmd_valid <= 1'b0;
                     r_frame_cnt <= r_frame_cnt + 16'd1;
                     r_rx_ready  <= 1'b1;
                     r_state     <= ST_IDLE;
                  end
               end
               default: begin
                  r_state     <= ST_IDLE;
                  r_rx_ready  <= 1'b1;
                  r_cmd_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rx_ready  = r_rx_ready;
   assign cmd_valid = r_cmd_valid;
   assign cmd_write = r_cmd_write;
   assign cmd_addr  = r_addr;
   assign cmd_wdata = r_wdata;
   assign err_valid = r_err_valid;
   assign err_code  = r_err_code;
   assign frame_cnt = r_frame_cnt;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios plus randomized frames.
module tb_uart_cmd_ctrl;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 20;

   logic          clk;
   logic          rst;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          err_valid;
   logic [1:0]    err_code;
   logic [15:0]   frame_cnt;
   logic [7:0]    err_cnt;

   uart_cmd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .err_valid(err_valid),
      .err_code(err_code), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   int          total = 0;
   int          bad   = 0;
   cmd_t        mon_cmd[$];
   logic [1:0]  mon_err[$];
   cmd_t        exp_cmd[$];
   logic [1:0]  exp_err[$];
   logic [7:0]  frame_q[$];
   logic [15:0] exp_frame_cnt;
   int          exp_err_cnt;

   // Capture completed command handshakes and error pulses between clock edges.
   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_valid && cmd_ready) mon_cmd.push_back({cmd_write, cmd_addr, cmd_wdata});
         if (err_valid) mon_err.push_back(err_code);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int w;
      w = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && w < 100) begin
         tick();
         w++;
      end
      total++;
      if (!rx_ready) begin
         bad++;
         $display("FAIL rx_ready_wait byte=%02h got=%0b want=1", b, rx_ready);
      end
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_frame();
      while (frame_q.size() > 0) send_byte(frame_q.pop_front());
   endtask

   // Frame builder from the wire format; also records the expected outcome.
   task automatic build_frame(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input bit corrupt);
      logic [7:0] cs;
      logic [7:0] opc;
      logic [7:0] flip;
      opc = wr ? 8'h01 : 8'h02;
      cs  = opc;
      frame_q.push_back(8'hA5);
      frame_q.push_back(opc);
      for (int i = 3; i >= 0; i--) begin
         frame_q.push_back(a[i*8 +: 8]);
         cs ^= a[i*8 +: 8];
      end
      if (wr) begin
         for (int i = 3; i >= 0; i--) begin
            frame_q.push_back(d[i*8 +: 8]);
            cs ^= d[i*8 +: 8];
         end
      end
      flip = 8'($urandom_range(1, 255));
      if (corrupt) begin
         frame_q.push_back(cs ^ flip);
         exp_err.push_back(2'b10);
         if (exp_err_cnt < 255) exp_err_cnt++;
      end else begin
         frame_q.push_back(cs);
         exp_cmd.push_back({wr, a, wr ? d : 32'h0});
         exp_frame_cnt++;
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      cmd_ready = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      mon_cmd.delete();
      mon_err.delete();
      exp_cmd.delete();
      exp_err.delete();
      exp_frame_cnt = 16'h0;
      exp_err_cnt   = 0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      cmd_ready = 1'b1;
      tick();
      total++;
      if (rx_ready !== 1'b1) begin
         bad++; $display("FAIL reset_rx_ready got=%0b want=1", rx_ready);
      end
      total++;
      if ({cmd_valid, cmd_write, err_valid, err_code, frame_cnt, err_cnt} !== 29'h0) begin
         bad++; $display("FAIL reset_ctrl_outs got=%h want=0",
                         {cmd_valid, cmd_write, err_valid, err_code, frame_cnt, err_cnt});
      end
      total++;
      if ({cmd_addr, cmd_wdata} !== 64'h0) begin
         bad++; $display("FAIL reset_fields got=%h want=0", {cmd_addr, cmd_wdata});
      end
      do_reset();
   endtask

   task automatic test_write();
      logic [7:0] wf [11];
      cmd_t       got;
      wf = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h33};
      foreach (wf[i]) frame_q.push_back(wf[i]);
      send_frame();
      repeat (4) tick();
      total++;
      if (mon_cmd.size() != 1) begin
         bad++; $display("FAIL write_cmd_count got=%0d want=1", mon_cmd.size());
      end else begin
         got = mon_cmd.pop_front();
         total++;
         if (got !== {1'b1, 32'h0000_1000, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL write_cmd got=%h want=%h", got, {1'b1, 32'h0000_1000, 32'hDEAD_BEEF});
         end
      end
      total++;
      if (frame_cnt !== 16'd1) begin
         bad++; $display("FAIL write_frame_cnt got=%0d want=1", frame_cnt);
      end
      total++;
      if (mon_err.size() != 0) begin
         bad++; $display("FAIL write_no_err got=%0d want=0", mon_err.size());
      end
      mon_cmd.delete();
      mon_err.delete();
      exp_frame_cnt = 16'd1;
   endtask

   task automatic test_read();
      logic [7:0] rf [7];
      cmd_t       got;
      rf = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h04, 8'h06};
      foreach (rf[i]) frame_q.push_back(rf[i]);
      send_frame();
      repeat (4) tick();
      total++;
      if (mon_cmd.size() != 1) begin
         bad++; $display("FAIL read_cmd_count got=%0d want=1", mon_cmd.size());
      end else begin
         got = mon_cmd.pop_front();
         total++;
         if (got !== {1'b0, 32'h0000_0004, 32'h0}) begin
            bad++; $display("FAIL read_cmd got=%h want=%h", got, {1'b0, 32'h0000_0004, 32'h0});
         end
      end
      exp_frame_cnt++;
      total++;
      if (frame_cnt !== exp_frame_cnt) begin
         bad++; $display("FAIL read_frame_cnt got=%0d want=%0d", frame_cnt, exp_frame_cnt);
      end
      mon_cmd.delete();
      mon_err.delete();
   endtask

   task automatic test_noise_bad_csum();
      logic [7:0] nf [9];
      nf = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h04, 8'h07};
      foreach (nf[i]) frame_q.push_back(nf[i]);
      send_frame();
      repeat (4) tick();
      total++;
      if (mon_err.size() != 1 || mon_err[0] !== 2'b10) begin
         bad++; $display("FAIL csum_err got_n=%0d got_code=%0b want_n=1 want_code=10",
                         mon_err.size(), err_code);
      end
      exp_err_cnt++;
      total++;
      if (err_cnt !== 8'(exp_err_cnt)) begin
         bad++; $display("FAIL csum_err_cnt got=%0d want=%0d", err_cnt, exp_err_cnt);
      end
      total++;
      if (mon_cmd.size() != 0) begin
         bad++; $display("FAIL csum_no_cmd got=%0d want=0", mon_cmd.size());
      end
      mon_cmd.delete();
      mon_err.delete();
   endtask

   task automatic test_bad_opc();
      logic [31:0] a;
      logic [31:0] d;
      send_byte(8'hA5);
      send_byte(8'h7E);
      exp_err.push_back(2'b01);
      exp_err_cnt++;
      a = $urandom();
      d = $urandom();
      build_frame(1'b1, a, d, 1'b0);
      send_frame();
      repeat (4) tick();
      total++;
      if (mon_err.size() != 1 || mon_err[0] !== 2'b01) begin
         bad++; $display("FAIL opc_err got_n=%0d got_code=%0b want_n=1 want_code=01",
                         mon_err.size(), err_code);
      end
      total++;
      if (mon_cmd.size() != 1 || mon_cmd[0] !== exp_cmd[0]) begin
         bad++; $display("FAIL opc_recover got_n=%0d want=%h", mon_cmd.size(), exp_cmd[0]);
      end
      total++;
      if (err_cnt !== 8'(exp_err_cnt) || frame_cnt !== exp_frame_cnt) begin
         bad++; $display("FAIL opc_counts got=%0d/%0d want=%0d/%0d",
                         err_cnt, frame_cnt, exp_err_cnt, exp_frame_cnt);
      end
      mon_cmd.delete(); mon_err.delete(); exp_cmd.delete(); exp_err.delete();
   endtask

   task automatic test_timeout();
      logic [31:0] d;
      // Expiry: the error appears exactly after the TMO-th idle cycle.
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      for (int i = 1; i < TMO; i++) begin
         tick();
         total++;
         if (err_valid !== 1'b0) begin
            bad++; $display("FAIL timeout_early idle=%0d got=%0b want=0", i, err_valid);
         end
      end
      tick();
      total++;
      if (err_valid !== 1'b1 || err_code !== 2'b11) begin
         bad++; $display("FAIL timeout_fire got=%0b/%0b want=1/11", err_valid, err_code);
      end
      exp_err_cnt++;
      repeat (2) tick();
      // Byte presented on the last allowed idle cycle wins over the timeout.
      d = $urandom();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h12);
      repeat (TMO - 1) tick();
      mon_err.delete();
      send_byte(8'h34);
      frame_q.push_back(8'h56);
      frame_q.push_back(8'h78);
      for (int i = 3; i >= 0; i--) frame_q.push_back(d[i*8 +: 8]);
      frame_q.push_back(8'h01 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0]);
      send_frame();
      repeat (4) tick();
      exp_frame_cnt++;
      total++;
      if (mon_err.size() != 0) begin
         bad++; $display("FAIL timeout_suppress got_n=%0d want=0", mon_err.size());
      end
      total++;
      if (mon_cmd.size() != 1 || mon_cmd[0] !== {1'b1, 32'h1234_5678, d}) begin
         bad++; $display("FAIL timeout_late_cmd got_n=%0d want=%h", mon_cmd.size(), {1'b1, 32'h1234_5678, d});
      end
      total++;
      if (err_cnt !== 8'(exp_err_cnt)) begin
         bad++; $display("FAIL timeout_err_cnt got=%0d want=%0d", err_cnt, exp_err_cnt);
      end
      mon_cmd.delete(); mon_err.delete(); exp_cmd.delete();
   endtask

   task automatic test_backpressure();
      cmd_t want;
      cmd_ready = 1'b0;
      build_frame(1'b1, $urandom(), $urandom(), 1'b0);
      want = exp_cmd.pop_front();
      send_frame();
      for (int i = 0; i < 5; i++) begin
         total++;
         if (cmd_valid !== 1'b1 || rx_ready !== 1'b0 ||
             {cmd_write, cmd_addr, cmd_wdata} !== want) begin
            bad++; $display("FAIL bp_hold cyc=%0d got=%0b/%0b/%h want=1/0/%h", i, cmd_valid,
                            rx_ready, {cmd_write, cmd_addr, cmd_wdata}, want);
         end
         tick();
      end
      cmd_ready = 1'b1;
      tick();
      total++;
      if (cmd_valid !== 1'b0 || frame_cnt !== exp_frame_cnt || rx_ready !== 1'b1) begin
         bad++; $display("FAIL bp_release got=%0b/%0d/%0b want=0/%0d/1", cmd_valid, frame_cnt,
                         rx_ready, exp_frame_cnt);
      end
      repeat (3) tick();
      total++;
      if (mon_cmd.size() != 1 || mon_cmd[0] !== want) begin
         bad++; $display("FAIL bp_once got_n=%0d want_n=1", mon_cmd.size());
      end
      mon_cmd.delete(); mon_err.delete();
   endtask

   task automatic test_reset_midframe();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'hC3);
      send_byte(8'h3C);
      rst = 1'b1;
      #1;
      total++;
      if ({cmd_valid, cmd_write, err_valid, err_code, frame_cnt, err_cnt, cmd_addr, cmd_wdata} !== 93'h0
          || rx_ready !== 1'b1) begin
         bad++; $display("FAIL midreset_outs got_addr=%h got_rdy=%0b want=0/1", cmd_addr, rx_ready);
      end
      do_reset();
      build_frame(1'b0, $urandom(), 32'h0, 1'b0);
      send_frame();
      repeat (4) tick();
      total++;
      if (mon_cmd.size() != 1 || mon_cmd[0] !== exp_cmd[0] || frame_cnt !== 16'd1) begin
         bad++; $display("FAIL midreset_next got_n=%0d cnt=%0d want=%h cnt=1", mon_cmd.size(),
                         frame_cnt, exp_cmd[0]);
      end
      mon_cmd.delete(); mon_err.delete(); exp_cmd.delete();
   endtask

   task automatic test_random_frames();
      int         kind;
      logic [7:0] b;
      for (int it = 0; it < 30; it++) begin
         kind = $urandom_range(0, 4);
         case (kind)
            0: build_frame(1'b1, $urandom(), $urandom(), 1'b0);
            1: build_frame(1'b0, $urandom(), $urandom(), 1'b0);
            2: build_frame(1'($urandom_range(0, 1)), $urandom(), $urandom(), 1'b1);
            3: begin
               b = 8'($urandom());
               while (b == 8'h01 || b == 8'h02) b = 8'($urandom());
               frame_q.push_back(8'hA5);
               frame_q.push_back(b);
               exp_err.push_back(2'b01);
               if (exp_err_cnt < 255) exp_err_cnt++;
            end
            default: begin
               for (int n = 0; n < 3; n++) begin
                  b = 8'($urandom());
                  if (b != 8'hA5) frame_q.push_back(b);
               end
               build_frame(1'b1, $urandom(), $urandom(), 1'b0);
            end
         endcase
         send_frame();
         repeat (3) tick();
         total++;
         if (mon_cmd.size() != exp_cmd.size() || mon_err.size() != exp_err.size()) begin
            bad++; $display("FAIL rand_counts it=%0d got=%0d/%0d want=%0d/%0d", it,
                            mon_cmd.size(), mon_err.size(), exp_cmd.size(), exp_err.size());
         end else begin
            foreach (exp_cmd[i]) begin
               total++;
               if (mon_cmd[i] !== exp_cmd[i]) begin
                  bad++; $display("FAIL rand_cmd it=%0d got=%h want=%h", it, mon_cmd[i], exp_cmd[i]);
               end
            end
            foreach (exp_err[i]) begin
               total++;
               if (mon_err[i] !== exp_err[i]) begin
                  bad++; $display("FAIL rand_err it=%0d got=%0b want=%0b", it, mon_err[i], exp_err[i]);
               end
            end
         end
         total++;
         if (frame_cnt !== exp_frame_cnt || err_cnt !== 8'(exp_err_cnt)) begin
            bad++; $display("FAIL rand_stats it=%0d got=%0d/%0d want=%0d/%0d", it, frame_cnt,
                            err_cnt, exp_frame_cnt, exp_err_cnt);
         end
         mon_cmd.delete(); mon_err.delete(); exp_cmd.delete(); exp_err.delete();
      end
   endtask

   task automatic test_err_saturate();
      for (int i = 0; i < 260; i++) begin
         send_byte(8'hA5);
         send_byte(8'hFE);
         if (exp_err_cnt < 255) exp_err_cnt++;
      end
      repeat (2) tick();
      total++;
      if (err_cnt !== 8'(exp_err_cnt) || exp_err_cnt != 255) begin
         bad++; $display("FAIL err_saturate got=%0d want=255", err_cnt);
      end
      total++;
      if (mon_err.size() != 260) begin
         bad++; $display("FAIL err_pulses got=%0d want=260", mon_err.size());
      end
      mon_err.delete();
   endtask

   initial begin
      exp_frame_cnt = 16'h0;
      exp_err_cnt   = 0;
      test_reset();
      test_write();
      test_read();
      test_noise_bad_csum();
      test_bad_opc();
      test_timeout();
      test_backpressure();
      test_reset_midframe();
      test_random_frames();
      test_err_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command-frame controller that sits directly behind the UART receiver. It consumes received bytes over a valid/ready handshake and parses them into single bus commands (read or write, address, write data). Each command is issued to the system-bus master side on a valid/ready port. It validates the opcode and checksum, enforces an inter-byte timeout, throttles the receiver while a command is pending, and reports errors and statistics.

Parameters:
ADDR_WIDTH, 32, bus address width; multiple of 8; sent MSB byte first.
DATA_WIDTH, 32, bus write-data width; multiple of 8; sent MSB byte first.
TIMEOUT_CYCLES, 100000, idle clocks allowed between bytes inside a frame; must be >= 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
rx_data  in  8  byte from UART receiver
rx_valid  in  1  rx_data valid
rx_ready  out  1  controller accepts byte; transfer = rx_valid && rx_ready
cmd_valid  out  1  command pending
cmd_ready  in  1  bus side accepts command
cmd_write  out  1  1 = write, 0 = read
cmd_addr  out  ADDR_WIDTH  command address
cmd_wdata  out  DATA_WIDTH  write data; 0 for reads
err_valid  out  1  one-cycle error pulse
err_code  out  2  01 bad opcode, 10 checksum, 11 timeout; held until the next error
frame_cnt  out  16  commands issued (wraps)
err_cnt  out  8  errors seen (saturates at 255)

Behaviour:
- Reset: state IDLE. All outputs 0 except rx_ready = 1. Reset mid-frame discards the partial frame and any pending command.
- Frame format: SYNC 0xA5, OPC, ADDR bytes, [DATA bytes, writes only], CSUM.
- OPC 0x01 = write, 0x02 = read.
- CSUM = XOR of OPC, all ADDR bytes and all DATA bytes. SYNC is not included.
- States: IDLE, OPC, ADDR, DATA, CSUM, ISSUE.
- rx_ready = 1 in every state except ISSUE, where it is 0.
- IDLE: accepted byte 0xA5 -> OPC. Any other byte is dropped silently (no error).
- OPC:
  - 0x01 or 0x02 -> ADDR; latch cmd_write; init checksum to the opcode byte.
  - Any other value -> IDLE with error code 01.
- ADDR:
  - Shift bytes into the address register, MSB first; byte counter runs 0..ADDR_WIDTH/8-1.
  - After the last byte: write -> DATA, read -> CSUM.
- DATA: same scheme as ADDR for DATA_WIDTH/8 bytes, then -> CSUM.
- CSUM:
  - Byte equals running XOR -> ISSUE.
  - Otherwise -> IDLE with error code 10; no command is issued.
- ISSUE:
  - cmd_valid is registered and rises the cycle after the CSUM byte is accepted.
  - cmd_write/addr/wdata are stable while cmd_valid && !cmd_ready.
  - On cmd_valid && cmd_ready: cmd_valid drops next cycle, frame_cnt++ (0xFFFF wraps to 0), -> IDLE.
- Read commands drive cmd_wdata = 0.
- Timeout:
  - Counter runs in OPC/ADDR/DATA/CSUM; it is cleared on every accepted byte and on entry to IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1 with no transfer that cycle -> IDLE with error code 11.
  - A byte accepted in that same cycle wins; no timeout is raised.
  - No timeout applies in IDLE or ISSUE.
- Error: err_valid pulses exactly 1 cycle, registered, coincident with entry to IDLE. err_code updates on that cycle. err_cnt increments unless already 255.
- A SYNC byte received mid-frame has no special meaning; it is treated as ordinary data.

Decomposition:
- Package uart_cmd_pkg:
  - state enum type
  - SYNC_BYTE = 8'hA5
  - OPC_WRITE = 8'h01, OPC_READ = 8'h02
  - ERR_OPC = 2'b01, ERR_CSUM = 2'b10, ERR_TIMEOUT = 2'b11
- One natural sub-module: uart_cmd_timeout. Inputs: clear, enable. Output: expire. Parameterised by TIMEOUT_CYCLES.
- FSM, shift registers and counters stay in uart_cmd_ctrl.

Test Plan:
- Write frame A5 01 00 00 10 00 DE AD BE EF 33, cmd_ready = 1 -> one cmd_valid with write = 1, addr = 0x00001000, wdata = 0xDEADBEEF; frame_cnt = 1; no err_valid.
- Read frame A5 02 00 00 00 04 06 -> cmd_valid with write = 0, addr = 0x00000004, wdata = 0.
- Leading noise 00 FF then the read frame with last byte 07 -> noise ignored; err_valid pulse with err_code = 10; err_cnt = 1; no cmd_valid.
- A5 then 0x7E -> err_code = 01, back to IDLE. A valid frame sent immediately afterwards is accepted.
- A5 01 00, then TIMEOUT_CYCLES idle cycles (TIMEOUT_CYCLES = 20 in test) -> err_code = 11 on the 20th cycle. A byte arriving on the 20th cycle instead suppresses the timeout.
- cmd_ready held low for 5 cycles during a valid write -> rx_ready = 0 and cmd fields stable for the whole wait; command issued once. Asserting rst during the ADDR bytes clears all outputs to reset values, and the next frame parses correctly.
